apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_master_pkg.sv | 14 +
 rtl/apb_timeout_counter.sv | 42 ++++
 rtl/apb_req_master.sv | 142 ++++++++++++++
 tb/tb_apb_req_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the request-to-APB master bridge.
// Holds the FSM state encoding and the default ACCESS-phase timeout.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase wait cycles and flags the cycle whose increment reaches
// the timeout limit, so the master can abort on that same edge.
module apb_timeout_counter
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_CNT_C = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT_C  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter: cleared per transfer, saturates at the limit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != MAX_CNT_C)) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Expiry fires in the wait cycle whose increment lands on the limit.
  always_comb begin
    expired = 1'b0;
    if (enable && (count_r == LAST_CNT_C)) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/apb_req_master.sv
// Bridges a valid/ready request/response channel onto an APB master port,
// with a bounded ACCESS phase that aborts with an error on slave timeout.
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_we,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy
);

  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK_C = {{(APB_ADDR_WIDTH-2){1'b1}}, 2'b00};

  apb_state_e state_r;
  apb_state_e state_nxt_s;
  logic       cnt_clear_s;
  logic       cnt_en_s;
  logic       expired_s;
  logic       accept_s;

  assign req_ready   = (state_r == IDLE);
  assign accept_s    = req_valid && (state_r == IDLE);
  assign cnt_clear_s = (state_r == SETUP);
  assign cnt_en_s    = (state_r == ACCESS) && !PREADY;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; PREADY wins over a simultaneous timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = ACCESS;
      end
      ACCESS: begin
        if (PREADY || expired_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      PSEL      <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
      PENABLE   <= (state_nxt_s == ACCESS);
      rsp_valid <= (state_nxt_s == RESP);
      busy      <= (state_nxt_s != IDLE);
    end
  end

  // Request latch; these hold their value between transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= 32'h0000_0000;
    end else if (accept_s) begin
      PADDR  <= req_addr & ADDR_MASK_C;
      PWRITE <= req_we;
      PWDATA <= req_wdata;
    end
  end

  // Response capture: slave data only sampled on a completing ACCESS cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (state_r == ACCESS) begin
      if (PREADY) begin
        rsp_rdata <= PWRITE ? 32'h0000_0000 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (expired_s) begin
        rsp_rdata <= 32'h0000_0000;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: transaction-level timeline model
// compared against the DUT every cycle, plus directed literal checks.
module tb_apb_req_master;

  localparam int AW  = 12;
  localparam int TMO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR, busy;

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  // Model expectations for the current cycle
  logic          e_req_ready, e_busy, e_psel, e_penable, e_rsp_valid, e_err, e_pwrite;
  logic [31:0]   e_rdata, e_pwdata;
  logic [AW-1:0] e_paddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_req_ready));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("psel",      32'(PSEL),      32'(e_psel));
      chk("penable",   32'(PENABLE),   32'(e_penable));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("paddr",     32'(PADDR),     32'(e_paddr));
      chk("pwrite",    32'(PWRITE),    32'(e_pwrite));
      chk("pwdata",    PWDATA,         e_pwdata);
      if (e_rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err",   32'(rsp_err), 32'(e_err));
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_exp(input logic rr, input logic bs, input logic ps, input logic pe, input logic rv);
    e_req_ready = rr; e_busy = bs; e_psel = ps; e_penable = pe; e_rsp_valid = rv;
  endtask

  task automatic slave_noise();
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
  endtask

  // Requests presented while busy must be ignored.
  task automatic req_noise();
    req_valid = 1'($urandom); req_addr = AW'($urandom); req_we = 1'($urandom); req_wdata = $urandom;
    rsp_ready = 1'($urandom);
  endtask

  task automatic t_idle();
    req_valid = 1'b0; rsp_ready = 1'($urandom); slave_noise();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic t_accept(input logic [AW-1:0] addr, input logic we, input logic [31:0] wd);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd;
    rsp_ready = 1'($urandom); slave_noise();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    e_paddr = addr & 12'hFFC; e_pwrite = we; e_pwdata = wd;
    req_noise(); slave_noise();
    set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  // One complete transfer; nwait = PREADY-low cycles the slave inserts.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic we, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rd, input logic se,
                         input int hold, input int gap,
                         output logic [31:0] o_rdata, output logic o_err, output int o_lat);
    bit tmo;
    int n;
    for (int g = 0; g < gap; g++) t_idle();
    t_accept(addr, we, wd);
    tmo = (nwait >= TMO);
    n   = tmo ? TMO : nwait + 1;
    for (int i = 0; i < n; i++) begin
      req_noise();
      if (!tmo && i == nwait) begin
        PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      set_exp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    e_rdata = tmo ? 32'h0 : (we ? 32'h0 : rd);
    e_err   = tmo ? 1'b1 : se;
    o_lat   = 2 + n;
    o_rdata = rsp_rdata;
    o_err   = rsp_err;
    for (int j = 0; j <= hold; j++) begin
      req_noise(); slave_noise();
      rsp_ready = (j == hold);
      set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;

  initial begin
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = 32'h0;
    rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    HRESETn = 1'b0;
    repeat (2) step();
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_paddr", 32'(PADDR), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    e_paddr = '0; e_pwrite = 1'b0; e_pwdata = 32'h0; e_rdata = 32'h0; e_err = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    t_idle();

    // Directed transfers with hand-computed results
    do_xfer(12'h008, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 0, r, e, lat);
    chk("d_write_lat", 32'(lat), 32'd3);
    chk("d_write_rdata", r, 32'h0);
    chk("d_write_err", 32'(e), 32'h0);
    chk("d_write_paddr", 32'(PADDR), 32'h008);
    chk("d_write_pwdata", PWDATA, 32'hDEADBEEF);

    do_xfer(12'h004, 1'b0, 32'h0, 3, 32'h0000A5A5, 1'b0, 3, 1, r, e, lat);
    chk("d_wait_lat", 32'(lat), 32'd6);
    chk("d_wait_rdata", r, 32'h0000A5A5);

    do_xfer(12'h00C, 1'b0, 32'h0, 20, 32'hFFFFFFFF, 1'b0, 0, 0, r, e, lat);
    chk("d_tmo_lat", 32'(lat), 32'd6);
    chk("d_tmo_rdata", r, 32'h0);
    chk("d_tmo_err", 32'(e), 32'h1);

    do_xfer(12'h013, 1'b0, 32'h0, 0, 32'h12345678, 1'b1, 1, 0, r, e, lat);
    chk("d_slverr_rdata", r, 32'h12345678);
    chk("d_slverr_err", 32'(e), 32'h1);
    chk("d_slverr_paddr", 32'(PADDR), 32'h010);

    do_xfer(12'h020, 1'b0, 32'h0, TMO - 1, 32'hC0FFEE00, 1'b0, 0, 0, r, e, lat);
    chk("d_edge_rdata", r, 32'hC0FFEE00);
    chk("d_edge_err", 32'(e), 32'h0);

    // Reset pulse in the middle of ACCESS
    t_accept(12'h030, 1'b1, 32'h5555AAAA);
    req_noise(); PREADY = 1'b0;
    set_exp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_en = 1'b0;
    req_valid = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("arst_psel", 32'(PSEL), 32'h0);
    chk("arst_penable", 32'(PENABLE), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pwdata", PWDATA, 32'h0);
    chk("arst_pwrite", 32'(PWRITE), 32'h0);
    step();
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    e_paddr = '0; e_pwrite = 1'b0; e_pwdata = 32'h0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    do_xfer(12'h044, 1'b0, 32'h0, 1, 32'h0BADF00D, 1'b0, 2, 0, r, e, lat);
    chk("post_rst_rdata", r, 32'h0BADF00D);
    chk("post_rst_err", 32'(e), 32'h0);

    // Randomized transfers
    for (int k = 0; k < 60; k++) begin
      do_xfer(AW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 6), $urandom,
              1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), r, e, lat);
    end
    t_idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
